mips_regfile_mp: RTL and testbench

- Multi-port, parametrised integer register file for the pipelined MIPS core; replaces the single-cycle two-read/one-write file.
- Provides NUM_RD registered read ports and NUM_WR write ports, a hardwired zero register, and a per-register pending scoreboard.
- Decode issues destination registers into the scoreboard. Writeback retires them.
- Read ports return data plus a busy flag with one-cycle latency.

---
 rtl/mips_regfile_mp.sv | 98 +++++++++
 tb/tb_mips_regfile_mp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp: multi-port integer register file with a per-register
// pending scoreboard for the pipelined MIPS core.
// Register 0 is hardwired to zero and can never be marked pending.
// Read ports are registered, with one cycle of latency.
// Optional macro MIPS_REGFILE_BYPASS_EN selects write-first forwarding.
// In write-first mode, a same-cycle write is forwarded into rd_data, and a
// same-cycle scoreboard update is forwarded into rd_busy.
// When the macro is undefined the file is read-first: reads return pre-edge state.
module mips_regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR-1:0]          wr_clr,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       pend_any
);

    logic [DATA_W-1:0]          r_regs     [NUM_REGS];
    logic [NUM_REGS-1:0]        r_pend;
    logic [NUM_RD*DATA_W-1:0]   r_rd_data;
    logic [NUM_RD-1:0]          r_rd_busy;

    logic [DATA_W-1:0]          w_regs_nxt [NUM_REGS];
    logic [NUM_REGS-1:0]        w_pend_nxt;
    logic [NUM_RD*DATA_W-1:0]   w_rd_data;
    logic [NUM_RD-1:0]          w_rd_busy;

    // Next register/scoreboard state.
    // Later write ports override earlier ones, and an issue overrides a retire.
    always_comb begin
        w_regs_nxt = r_regs;
        w_pend_nxt = r_pend;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                w_regs_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
                if (wr_clr[j]) begin
                    w_pend_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
        end
        if (iss_en && (iss_addr != '0)) begin
            w_pend_nxt[iss_addr] = 1'b1;
        end
        w_regs_nxt[0] = '0;
        w_pend_nxt[0] = 1'b0;
    end

    // Read-port source selection: post-update state when forwarding, pre-edge otherwise.
    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i*ADDR_W +: ADDR_W] != '0) begin
`ifdef MIPS_REGFILE_BYPASS_EN
                w_rd_data[i*DATA_W +: DATA_W] = w_regs_nxt[rd_addr[i*ADDR_W +: ADDR_W]];
                w_rd_busy[i]                  = w_pend_nxt[rd_addr[i*ADDR_W +: ADDR_W]];
`else
                w_rd_data[i*DATA_W +: DATA_W] = r_regs[rd_addr[i*ADDR_W +: ADDR_W]];
                w_rd_busy[i]                  = r_pend[rd_addr[i*ADDR_W +: ADDR_W]];
`endif
            end
        end
    end

    // State and read-port registers; reset discards any in-flight update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_pend    <= '0;
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            r_regs    <= w_regs_nxt;
            r_pend    <= w_pend_nxt;
            r_rd_data <= w_rd_data;
            r_rd_busy <= w_rd_busy;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_busy  = r_rd_busy;
    assign pend_any = |r_pend;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed testbench for mips_regfile_mp (2 read ports, 2 write ports).
// Expectations follow MIPS_REGFILE_BYPASS_EN when it is defined for the build.
module tb_mips_regfile_mp;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned NUM_RD   = 2;
    localparam int unsigned NUM_WR   = 2;
    localparam int unsigned ADDR_W   = 5;

`ifdef MIPS_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                      clk;
    logic                      rst;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD*DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]         rd_busy;
    logic [NUM_WR-1:0]         wr_en;
    logic [NUM_WR*ADDR_W-1:0]  wr_addr;
    logic [NUM_WR*DATA_W-1:0]  wr_data;
    logic [NUM_WR-1:0]         wr_clr;
    logic                      iss_en;
    logic [ADDR_W-1:0]         iss_addr;
    logic                      pend_any;

    int checks;
    int failures;

    mips_regfile_mp #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_clr   (wr_clr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .pend_any (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_wr(input int p, input logic [4:0] a, input logic [31:0] d, input bit clr);
        wr_en[p]                = 1'b1;
        wr_addr[p*ADDR_W +: ADDR_W] = a;
        wr_data[p*DATA_W +: DATA_W] = d;
        wr_clr[p]               = clr;
    endtask

    task automatic drv_rd(input int p, input logic [4:0] a);
        rd_addr[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_clr   = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        rd_addr  = '0;
        idle();
        #1 rst = 1'b1;
        #2;
        check("reset_rd_data", rd_data[31:0], 32'h0);
        check("reset_rd_busy", 32'(rd_busy), 32'h0);
        check("reset_pend_any", 32'(pend_any), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Load r5, issue r6, then reset asynchronously mid-cycle.
        tick();
        drv_wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        idle();
        drv_rd(0, 5'd5); drv_rd(1, 5'd6);
        tick();
        check("pre_reset_r5", rd_data[31:0], 32'hDEADBEEF);
        check("pre_reset_busy_r6", 32'(rd_busy[1]), 32'h1);
        check("pre_reset_pend_any", 32'(pend_any), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rd_data", rd_data[31:0], 32'h0);
        check("async_rst_rd_busy", 32'(rd_busy), 32'h0);
        check("async_rst_pend_any", 32'(pend_any), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_reset_r5", rd_data[31:0], 32'h0);

        // Writes and issues to r0 are ignored.
        drv_wr(0, 5'd0, 32'hFFFFFFFF, 1'b0);
        iss_en = 1'b1; iss_addr = 5'd0;
        drv_rd(0, 5'd0); drv_rd(1, 5'd0);
        tick();
        check("r0_same_cycle_p0", rd_data[31:0], 32'h0);
        check("r0_same_cycle_busy", 32'(rd_busy), 32'h0);
        idle();
        tick();
        check("r0_p0", rd_data[31:0], 32'h0);
        check("r0_p1", rd_data[63:32], 32'h0);
        check("r0_busy", 32'(rd_busy), 32'h0);
        check("r0_pend_any", 32'(pend_any), 32'h0);

        // Basic write then read on one and both ports.
        drv_wr(0, 5'd7, 32'h12345678, 1'b0);
        tick();
        idle();
        drv_rd(0, 5'd7); drv_rd(1, 5'd0);
        tick();
        check("r7_p0", rd_data[31:0], 32'h12345678);
        drv_rd(1, 5'd7);
        tick();
        check("r7_both_p0", rd_data[31:0], 32'h12345678);
        check("r7_both_p1", rd_data[63:32], 32'h12345678);

        // Write/read collision on r9.
        drv_wr(0, 5'd9, 32'h00000001, 1'b0);
        tick();
        drv_wr(0, 5'd9, 32'hA5A5A5A5, 1'b0);
        drv_rd(1, 5'd9);
        tick();
        check("collide_r9", rd_data[63:32], BYP ? 32'hA5A5A5A5 : 32'h00000001);
        idle();
        tick();
        check("after_collide_r9", rd_data[63:32], 32'hA5A5A5A5);

        // Two ports writing r3: the higher port wins.
        drv_wr(0, 5'd3, 32'h11, 1'b0);
        drv_wr(1, 5'd3, 32'h22, 1'b0);
        drv_rd(1, 5'd3);
        tick();
        check("multi_wr_bypass_r3", rd_data[63:32], BYP ? 32'h22 : 32'h0);
        idle();
        drv_rd(0, 5'd3);
        tick();
        check("multi_wr_r3", rd_data[31:0], 32'h22);

        // Scoreboard: issue, retire, and same-cycle issue+retire on r4.
        drv_rd(0, 5'd4); drv_rd(1, 5'd0);
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        check("iss_pend_any", 32'(pend_any), 32'h1);
        check("iss_busy_same_cycle", 32'(rd_busy[0]), BYP ? 32'h1 : 32'h0);
        idle();
        tick();
        check("iss_busy_r4", 32'(rd_busy[0]), 32'h1);
        check("iss_busy_r0_port", 32'(rd_busy[1]), 32'h0);
        drv_wr(0, 5'd4, 32'h44, 1'b1);
        tick();
        check("retire_pend_any", 32'(pend_any), 32'h0);
        check("retire_busy_same_cycle", 32'(rd_busy[0]), BYP ? 32'h0 : 32'h1);
        idle();
        tick();
        check("retire_busy_r4", 32'(rd_busy[0]), 32'h0);
        check("retire_data_r4", rd_data[31:0], 32'h44);
        drv_wr(0, 5'd10, 32'h5, 1'b1);
        tick();
        check("clr_nonpending_pend_any", 32'(pend_any), 32'h0);
        idle();
        tick();
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        check("reiss_pend_any", 32'(pend_any), 32'h1);
        drv_wr(1, 5'd4, 32'h55, 1'b1);
        tick();
        check("set_over_clr_pend_any", 32'(pend_any), 32'h1);
        idle();
        tick();
        check("set_over_clr_busy", 32'(rd_busy[0]), 32'h1);
        check("set_over_clr_data", rd_data[31:0], 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
